// File: rtl/hazard_ctrl_if.sv
// ============================================================================
// Module  : hazard_ctrl_if
// Brief   : ID/EX hazard-detection inputs and pipeline control outputs.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface hazard_ctrl_if;
    logic [4:0]  id_rs1_addr;
    logic [4:0]  id_rs2_addr;
    logic        id_rs1_used;
    logic        id_rs2_used;
    logic [6:0]  ex_opcode;
    logic [4:0]  ex_rd_addr;
    logic        ex_jump;
    logic        mdu_start;
    logic        pc_stall;
    logic        if_id_stall;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        ex_stall;
    logic        mdu_busy;
    logic [31:0] stall_cycles;

    modport master (
        output id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
        output ex_opcode, ex_rd_addr, ex_jump, mdu_start,
        input  pc_stall, if_id_stall, if_id_flush, id_ex_flush,
        input  ex_stall, mdu_busy, stall_cycles
    );

    modport slave (
        input  id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
        input  ex_opcode, ex_rd_addr, ex_jump, mdu_start,
        output pc_stall, if_id_stall, if_id_flush, id_ex_flush,
        output ex_stall, mdu_busy, stall_cycles
    );
endinterface

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module  : hazard_ctrl
// Brief   : Pipeline hazard unit: load-use bubble, jump flush, MDU stall.
//           Optional MDU wait support enabled by macro HAZARD_MDU_STALL_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_ctrl #(
    parameter int MDU_LAT = 32
) (
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  hz
);

    localparam logic [6:0] c_OPC_LOAD = 7'b0000011;

    logic        w_load_use;
    logic        w_pc_stall;
    logic        w_if_id_stall;
    logic        w_if_id_flush;
    logic        w_id_ex_flush;
    logic        w_ex_stall;
    logic        w_mdu_busy;
    logic [31:0] r_stall_cycles;

    assign w_load_use = (hz.ex_opcode == c_OPC_LOAD) && (hz.ex_rd_addr != 5'd0) &&
                        ((hz.id_rs1_used && (hz.id_rs1_addr == hz.ex_rd_addr)) ||
                         (hz.id_rs2_used && (hz.id_rs2_addr == hz.ex_rd_addr)));

`ifdef HAZARD_MDU_STALL_EN
    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MDU_WAIT = 1'b1
    } state_t;

    localparam logic [5:0] c_CNT_INIT = 6'(MDU_LAT - 2);

    state_t     r_state;
    logic [5:0] r_cnt;

    // The start cycle is itself a stall cycle, so the wait phase lasts
    // MDU_LAT-2 cycles; cnt reaches zero on the edge that returns to RUN.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= RUN;
            r_cnt   <= 6'd0;
        end else begin
            case (r_state)
                RUN: begin
                    if (!hz.ex_jump && hz.mdu_start) begin
                        r_cnt   <= c_CNT_INIT;
                        r_state <= (c_CNT_INIT == 6'd0) ? RUN : MDU_WAIT;
                    end
                end
                MDU_WAIT: begin
                    r_cnt <= r_cnt - 6'd1;
                    if (r_cnt <= 6'd1) begin
                        r_state <= RUN;
                    end
                end
                default: r_state <= RUN;
            endcase
        end
    end

    always_comb begin
        w_pc_stall    = 1'b0;
        w_if_id_stall = 1'b0;
        w_if_id_flush = 1'b0;
        w_id_ex_flush = 1'b0;
        w_ex_stall    = 1'b0;
        w_mdu_busy    = 1'b0;
        if (rst) begin
            if (r_state == MDU_WAIT || hz.ex_jump == 1'b0 && hz.mdu_start) begin
                w_pc_stall    = 1'b1;
                w_if_id_stall = 1'b1;
                w_ex_stall    = 1'b1;
                w_mdu_busy    = 1'b1;
            end else if (hz.ex_jump) begin
                w_if_id_flush = 1'b1;
                w_id_ex_flush = 1'b1;
            end else if (w_load_use) begin
                w_pc_stall    = 1'b1;
                w_if_id_stall = 1'b1;
                w_id_ex_flush = 1'b1;
            end
        end
    end
`else
    wire w_unused_mdu_start = hz.mdu_start;

    always_comb begin
        w_pc_stall    = 1'b0;
        w_if_id_stall = 1'b0;
        w_if_id_flush = 1'b0;
        w_id_ex_flush = 1'b0;
        w_ex_stall    = 1'b0;
        w_mdu_busy    = 1'b0;
        if (rst) begin
            if (hz.ex_jump) begin
                w_if_id_flush = 1'b1;
                w_id_ex_flush = 1'b1;
            end else if (w_load_use) begin
                w_pc_stall    = 1'b1;
                w_if_id_stall = 1'b1;
                w_id_ex_flush = 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stall_cycles <= 32'd0;
        end else if (w_pc_stall && (r_stall_cycles != 32'hFFFF_FFFF)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign hz.pc_stall     = w_pc_stall;
    assign hz.if_id_stall  = w_if_id_stall;
    assign hz.if_id_flush  = w_if_id_flush;
    assign hz.id_ex_flush  = w_id_ex_flush;
    assign hz.ex_stall     = w_ex_stall;
    assign hz.mdu_busy     = w_mdu_busy;
    assign hz.stall_cycles = r_stall_cycles;

endmodule

`default_nettype wire

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MDU_LAT, default 32, meaning EX-stage cycles occupied by one multi-cycle MDU op (legal range 2..64).
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port id_rs1_addr / id_rs2_addr  input  5 each  source registers of the instruction in ID.
REQ-005 SHALL have port id_rs1_used / id_rs2_used  input  1 each  ID instruction actually reads that source.
REQ-006 SHALL have port ex_opcode  input  7  opcode currently in EX (output side of the ID/EX register).
REQ-007 SHALL have port ex_rd_addr  input  5  destination register of the EX instruction.
REQ-008 SHALL have port ex_jump  input  1  branch taken or jump resolved in EX this cycle.
REQ-009 SHALL have port mdu_start  input  1  EX instruction is a multi-cycle MDU op.
REQ-010 SHALL have port pc_stall / if_id_stall  output  1 each  hold PC and IF/ID contents.
REQ-011 SHALL have port if_id_flush  output  1  load NOP into IF/ID.
REQ-012 SHALL have port id_ex_flush  output  1  load NOP (OPC_ALI, all other fields 0) into ID/EX; drives its bubble_hold.
REQ-013 SHALL have port ex_stall  output  1  freeze EX and downstream pipeline registers.
REQ-014 SHALL have port mdu_busy  output  1  high while an MDU op is being waited on.
REQ-015 SHALL have port stall_cycles  output  32  saturating count of cycles with pc_stall high.

Function
REQ-016 SHALL implement FSM with two states, RUN and MDU_WAIT, plus 6-bit down-counter cnt.
REQ-017 load_use SHALL equal: ex_opcode==OPC_LOAD, ex_rd_addr!=0, and (id_rs1_used & id_rs1_addr==ex_rd_addr or id_rs2_used & id_rs2_addr==ex_rd_addr).
REQ-018 In RUN, priority SHALL be ex_jump > mdu_start > load_use; lower-priority events in the same cycle are ignored.
REQ-019 RUN & ex_jump: if_id_flush=1, id_ex_flush=1, all stalls 0, same cycle (combinational), state stays RUN.
REQ-020 RUN & mdu_start (no jump): pc_stall=if_id_stall=ex_stall=1, mdu_busy=1; next state MDU_WAIT, cnt loaded with MDU_LAT-2.
REQ-021 MDU_WAIT: pc_stall=if_id_stall=ex_stall=mdu_busy=1, flushes 0; cnt decrements each cycle; when cnt==0, next state RUN.
REQ-022 Total stall for one MDU op SHALL be exactly MDU_LAT-1 cycles, the EX instruction occupying EX for MDU_LAT cycles.
REQ-023 MDU_WAIT SHALL ignore ex_jump, mdu_start and load_use.
REQ-024 RUN & load_use (no jump, no mdu_start): pc_stall=if_id_stall=1, id_ex_flush=1, ex_stall=0; exactly one bubble.
REQ-025 RUN with no event: all control outputs 0.
REQ-026 stall_cycles SHALL increment on every cycle pc_stall=1 and hold at 32'hFFFF_FFFF.

Reset
REQ-027 rst low at a rising edge SHALL force state RUN, cnt=0, stall_cycles=0, including mid-MDU_WAIT.
REQ-028 While rst is low, all 1-bit control outputs SHALL read 0.

Configuration
REQ-029 Macro HAZARD_MDU_STALL_EN: defined -> MDU_WAIT, cnt and mdu_busy behave as above.
REQ-030 Without HAZARD_MDU_STALL_EN: mdu_start ignored, MDU_WAIT and cnt absent, mdu_busy tied 0, ex_stall tied 0.

Verification
REQ-031 ex_opcode=OPC_LOAD, ex_rd=5, id_rs2=5 used -> one cycle pc_stall=if_id_stall=id_ex_flush=1, then all 0; stall_cycles=1.
REQ-032 Same as REQ-031 with ex_rd=0 -> no stall, stall_cycles=0.
REQ-033 ex_jump=1 with load_use=1 same cycle -> if_id_flush=id_ex_flush=1, pc_stall=0.
REQ-034 MDU_LAT=32, mdu_start pulse -> mdu_busy high exactly 31 cycles, ex_jump raised mid-wait has no effect; stall_cycles=31.
REQ-035 rst low on 10th cycle of MDU_WAIT -> next cycle state RUN, all outputs 0, stall_cycles=0.
REQ-036 Build without HAZARD_MDU_STALL_EN, mdu_start=1 -> mdu_busy=ex_stall=pc_stall=0.
